jacaranda_uart_tx: RTL and testbench



---
 rtl/jacaranda_uart_pkg.sv | 21 ++
 rtl/jacaranda_sync_fifo.sv | 58 +++++
 rtl/jacaranda_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_jacaranda_uart_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/jacaranda_uart_pkg.sv
// Shared types and constants for the jacaranda UART.
// JACARANDA_UART_PARITY_EN adds the PARITY state (8E1 frames).
package jacaranda_uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef JACARANDA_UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/jacaranda_sync_fifo.sv
// DEPTH x WIDTH synchronous FIFO with first-word-fall-through read.
// Full and empty are derived from the occupancy counter.
module jacaranda_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level_reg == FULL_LEVEL);
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/jacaranda_uart_tx.sv
// Buffered UART transmitter: FIFO in front of an 8N1 serialiser.
// Define JACARANDA_UART_PARITY_EN for 8E1 (even parity) frames.
module jacaranda_uart_tx
  import jacaranda_uart_pkg::*;
#(
  parameter int CLK_DIV = 347,
  parameter int DEPTH   = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx_o,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  uart_tx_state_t state_reg, state_next;
  logic [15:0]    baud_cnt_reg, baud_cnt_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tx_o_reg, tx_o_next;
  logic           parity_next;
  logic           baud_done;
  logic           pop_req;
  logic [7:0]     fifo_data;
  logic           fifo_full;
  logic           fifo_empty;

  jacaranda_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop_req),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifdef JACARANDA_UART_PARITY_EN
  logic parity_reg;
`endif

  assign baud_done = (baud_cnt_reg == BAUD_LAST);
  assign tx_ready  = !fifo_full;
  assign tx_o      = tx_o_reg;
  assign busy      = (state_reg != ST_IDLE) || (fifo_level != '0);

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_done ? 16'd0 : baud_cnt_reg + 16'd1;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    pop_req       = 1'b0;
    tx_o_next     = LINE_IDLE;
`ifdef JACARANDA_UART_PARITY_EN
    parity_next   = parity_reg;
`else
    parity_next   = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        baud_cnt_next = 16'd0;
        if (!fifo_empty) begin
          pop_req     = 1'b1;
          shift_next  = fifo_data;
          parity_next = ^fifo_data;
          state_next  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_next   = ST_DATA;
          bit_idx_next = 3'd0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == BIT_LAST) begin
`ifdef JACARANDA_UART_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
`ifdef JACARANDA_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_done) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit so queued frames abut.
        if (baud_done) begin
          if (!fifo_empty) begin
            pop_req       = 1'b1;
            shift_next    = fifo_data;
            parity_next   = ^fifo_data;
            baud_cnt_next = 16'd0;
            state_next    = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_START:  tx_o_next = LINE_START;
      ST_DATA:   tx_o_next = shift_next[0];
`ifdef JACARANDA_UART_PARITY_EN
      ST_PARITY: tx_o_next = parity_next;
`endif
      ST_STOP:   tx_o_next = LINE_STOP;
      default:   tx_o_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= 16'd0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      tx_o_reg     <= LINE_IDLE;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_o_reg     <= tx_o_next;
    end
  end

`ifdef JACARANDA_UART_PARITY_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) parity_reg <= 1'b0;
    else          parity_reg <= parity_next;
  end
`else
  logic unused_parity;
  assign unused_parity = parity_next;
`endif

endmodule

// File: tb/tb_jacaranda_uart_tx.sv
// Scoreboard bench for jacaranda_uart_tx: accepted bytes are queued,
// a line monitor decodes each frame from tx_o and compares.
module tb_jacaranda_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef JACARANDA_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_o;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_level;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  jacaranda_uart_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_o       (tx_o),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Offer a byte from the negedge; returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 500; i++) begin
      acc = tx_ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    check("send_accept", {31'd0, acc}, 32'd1);
    if (acc) exp_q.push_back(b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && tx_o) break;
    end
    check("drain_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  // Measure cycles from the current negedge until busy falls.
  task automatic busy_cycles(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Line monitor: samples each bit mid-period on negedges.
  initial begin : monitor
    logic [NB-1:0] bits;
    logic [7:0]    exp_b;
    bit            ab;
    int            w;
    forever begin
      @(negedge clk);
      if (!rst && tx_o == 1'b0) begin
        ab = 1'b0;
        for (int b = 0; b < NB; b++) begin
          w = (b == 0) ? CLK_DIV / 2 : CLK_DIV;
          for (int i = 0; i < w; i++) begin
            @(negedge clk);
            if (rst) begin ab = 1'b1; break; end
          end
          if (ab) break;
          bits[b] = tx_o;
        end
        if (ab) begin
          $display("frame aborted by reset");
        end else if (exp_q.size() == 0) begin
          check("frame_unexpected", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          $display("frame data=%02h expected=%02h", bits[8:1], exp_b);
          check("frame_start", {31'd0, bits[0]}, 32'd0);
          check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_b});
`ifdef JACARANDA_UART_PARITY_EN
          check("frame_parity", {31'd0, bits[9]}, {31'd0, ^exp_b});
`endif
          check("frame_stop", {31'd0, bits[NB-1]}, 32'd1);
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    logic [7:0] burst [6];
    burst[0] = 8'h31; burst[1] = 8'h32; burst[2] = 8'hC4;
    burst[3] = 8'h8E; burst[4] = 8'h01; burst[5] = 8'h7F;

    @(negedge clk);
    check("rst_tx_o", {31'd0, tx_o}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: latency and frame length.
    send(8'h55);
    @(negedge clk);
    tx_valid = 1'b0;
    check("lat_pre_tx_o", {31'd0, tx_o}, 32'd1);
    check("lat_level1", {29'd0, fifo_level}, 32'd1);
    @(negedge clk);
    check("lat_fall", {31'd0, tx_o}, 32'd0);
    check("lat_level0", {29'd0, fifo_level}, 32'd0);
    busy_cycles(n);
    check("single_busy_len", n, FRAME);
    wait_idle();
    $display("single byte 0x55 done");

    // Back-to-back frames.
    send(8'h00);
    send(8'hFF);
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b_level", {29'd0, fifo_level}, 32'd1);
    check("b2b_start1", {31'd0, tx_o}, 32'd0);
    for (int i = 1; i < FRAME; i++) @(negedge clk);
    check("b2b_stop1", {31'd0, tx_o}, 32'd1);
    @(negedge clk);
    check("b2b_start2", {31'd0, tx_o}, 32'd0);
    check("b2b_level0", {29'd0, fifo_level}, 32'd0);
    busy_cycles(n);
    check("b2b_busy_len", n, FRAME);
    wait_idle();
    $display("back-to-back 0x00 0xFF done");

    // Fill the FIFO with tx_valid held.
    for (int i = 0; i < 6; i++) begin
      send(burst[i]);
      if (i == 4) begin
        @(negedge clk);
        check("full_ready", {31'd0, tx_ready}, 32'd0);
        check("full_level", {29'd0, fifo_level}, 32'd4);
      end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    $display("full fifo burst done");

    // Reset during data bit 3 with two bytes queued.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    @(negedge clk);
    tx_valid = 1'b0;
    check("mid_level", {29'd0, fifo_level}, 32'd2);
    repeat (16) @(negedge clk);
    check("mid_bit3", {31'd0, tx_o}, 32'd0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_tx_o", {31'd0, tx_o}, 32'd1);
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hA5);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    $display("reset mid-frame then 0xA5 done");

`ifdef JACARANDA_UART_PARITY_EN
    send(8'h07);
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    busy_cycles(n);
    check("par07_len", n, 11 * CLK_DIV);
    wait_idle();
    send(8'h03);
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    busy_cycles(n);
    check("par03_len", n, 11 * CLK_DIV);
    wait_idle();
    $display("parity frames done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
